sht10_meas_scheduler: RTL and testbench
=======================================

Name: sht10_meas_scheduler

Overview:
Sequences the sht10_sensor measurement core: issues alternating temperature and humidity conversions on a periodic schedule, enforces a per-conversion timeout, and recovers from communication errors with a connection reset and bounded retries. Latches raw results for the display/conversion logic. Sits between top-level control (enable, one-shot trigger) and the sensor core's start/select/reset_conn inputs.

Parameters:
PERIOD_CYCLES, 100_000_000, idle gap between the end of one T+RH pair and the next start (1 s at 100 MHz)
TIMEOUT_CYCLES, 40_000_000, max cycles from start pulse to done/error (400 ms, above the 320 ms 14-bit conversion time)
RECOVER_CYCLES, 1_000_000, wait after a reset_conn pulse before retrying
MAX_RETRY, 3, failed attempts allowed per measurement before declaring fault

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  periodic scheduling on
trigger  in  1  one-cycle pulse; starts one T+RH pair when IDLE
clear_fault  in  1  one-cycle pulse; clears fault
sens_start  out  1  one-cycle start pulse to core
sens_sel  out  1  0 = temperature, 1 = humidity; stable from start to done/error
sens_reset_conn  out  1  one-cycle connection-reset pulse to core
sens_done  in  1  one-cycle pulse, conversion complete, sens_data valid
sens_error  in  1  one-cycle pulse, core detected com/CRC error
sens_data  in  16  raw conversion result
temp_raw  out  14  last good temperature (sens_data[13:0])
rh_raw  out  12  last good humidity (sens_data[11:0])
temp_valid  out  1  sticky, set on first good temperature
rh_valid  out  1  sticky, set on first good humidity
sample_strobe  out  1  one-cycle pulse when a T+RH pair completes successfully
fault  out  1  sticky, retries exhausted
err_count  out  8  saturating count of error/timeout events
busy  out  1  high in any state other than IDLE/GAP

Behaviour:
- Reset: state IDLE; all outputs 0; counters and retry count 0.
- States: IDLE, START_T, WAIT_T, START_H, WAIT_H, RECOVER, GAP.
- IDLE: enable=1 or trigger=1 -> START_T next cycle.
- START_T/START_H: sens_start=1 for exactly one cycle, sens_sel set (0/1); timeout counter cleared -> WAIT_T/WAIT_H.
- WAIT_x: sens_done -> latch data (temp_raw or rh_raw), set matching valid, clear retry count; WAIT_T -> START_H; WAIT_H -> sample_strobe=1 for one cycle, -> GAP.
- sens_error, or timeout counter reaching TIMEOUT_CYCLES-1 with no done: err_count+1 (saturates at 255), retry count+1, sens_reset_conn=1 for one cycle, -> RECOVER.
- sens_done and sens_error in the same cycle: error wins and no data is latched.
- done/error outside WAIT_x: ignored.
- RECOVER: wait RECOVER_CYCLES. If retry count < MAX_RETRY, retry the same measurement (START_T or START_H, same sens_sel). Otherwise set fault, clear retry count, skip the rest of the pair (no strobe), -> GAP.
- GAP: count PERIOD_CYCLES, then -> START_T if enable=1, else IDLE. trigger in GAP is ignored.
- enable falling mid-pair: the current pair runs to completion (including retries), then GAP -> IDLE.
- fault: cleared only by clear_fault or reset. clear_fault coincident with a new fault leaves fault set. Scheduling continues while fault=1.
- temp_raw/rh_raw hold their last good value across errors and faults.
- Latency: sens_start occurs 1 cycle after the IDLE trigger; data appears on outputs 1 cycle after sens_done.

Test Plan:
(Parameters for bench: PERIOD=1000, TIMEOUT=200, RECOVER=50, MAX_RETRY=2.)
- Normal pair: enable=1; model answers done 100 cycles after each start with data 0x1A2B then 0x0567 -> temp_raw=0x1A2B, rh_raw=0x567, both valid, one sample_strobe, next sens_start 1000 cycles after GAP entry.
- Error then recover: first T start answered with sens_error -> err_count=1, one sens_reset_conn pulse, retry start with sens_sel=0 exactly 50 cycles later; done -> pair completes, fault=0.
- Timeout exhaustion: no responses on the H measurement -> two timeouts 200 cycles each, err_count=2, fault=1, no sample_strobe, rh_raw unchanged; clear_fault -> fault=0.
- Simultaneous done+error in WAIT_T -> treated as error, temp_raw not updated, retry issued.
- One-shot: enable=0, trigger pulse -> exactly one T+RH pair, then IDLE with busy=0; trigger during GAP ignored; enable dropped mid-WAIT_H -> pair finishes, returns to IDLE.
- Async reset asserted in WAIT_H -> all outputs 0 immediately; no sens_start until a new trigger.

Source files
------------

// File: rtl/sht10_meas_scheduler_if.sv
// rtl/sht10_meas_scheduler_if.sv - Control, sensor-core and result signals of the SHT10 measurement scheduler
// master is the scheduler side; slave is the surrounding control/sensor/display side.
interface sht10_meas_scheduler_if;
   logic        enable_i;
   logic        trigger_i;
   logic        clear_fault_i;
   logic        sens_done_i;
   logic        sens_error_i;
   logic [15:0] sens_data_i;
   logic        sens_start_o;
   logic        sens_sel_o;
   logic        sens_reset_conn_o;
   logic [13:0] temp_raw_o;
   logic [11:0] rh_raw_o;
   logic        temp_valid_o;
   logic        rh_valid_o;
   logic        sample_strobe_o;
   logic        fault_o;
   logic [7:0]  err_count_o;
   logic        busy_o;

   modport master (
      input  enable_i, trigger_i, clear_fault_i, sens_done_i, sens_error_i, sens_data_i,
      output sens_start_o, sens_sel_o, sens_reset_conn_o, temp_raw_o, rh_raw_o,
             temp_valid_o, rh_valid_o, sample_strobe_o, fault_o, err_count_o, busy_o
   );

   modport slave (
      output enable_i, trigger_i, clear_fault_i, sens_done_i, sens_error_i, sens_data_i,
      input  sens_start_o, sens_sel_o, sens_reset_conn_o, temp_raw_o, rh_raw_o,
             temp_valid_o, rh_valid_o, sample_strobe_o, fault_o, err_count_o, busy_o
   );
endinterface

// File: rtl/sht10_meas_scheduler.sv
// rtl/sht10_meas_scheduler.sv - Periodic T/RH conversion sequencer with timeout, retry and fault handling
// One shared counter times the conversion timeout, the post-reset recovery wait and the inter-pair gap.
module sht10_meas_scheduler #(
   parameter int unsigned PERIOD_CYCLES  = 100_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 40_000_000,
   parameter int unsigned RECOVER_CYCLES = 1_000_000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input logic                    clock_i,
   input logic                    reset_i,
   sht10_meas_scheduler_if.master bus_if
);
   typedef enum logic [2:0] {
      S_IDLE, S_START_T, S_WAIT_T, S_START_H, S_WAIT_H, S_RECOVER, S_GAP
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] retry_q, retry_d;
   logic [7:0]  err_count_q, err_count_d;
   logic [13:0] temp_raw_q, temp_raw_d;
   logic [11:0] rh_raw_q, rh_raw_d;
   logic        temp_valid_q, temp_valid_d;
   logic        rh_valid_q, rh_valid_d;
   logic        start_q, start_d;
   logic        sel_q, sel_d;
   logic        reset_conn_q, reset_conn_d;
   logic        strobe_q, strobe_d;
   logic        fault_q, fault_d;
   logic        busy_q, busy_d;
   logic        timed_out;
   logic        unused_data_bits;

   assign unused_data_bits = ^bus_if.sens_data_i[15:14];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 32'd1;
      retry_d      = retry_q;
      err_count_d  = err_count_q;
      temp_raw_d   = temp_raw_q;
      rh_raw_d     = rh_raw_q;
      temp_valid_d = temp_valid_q;
      rh_valid_d   = rh_valid_q;
      sel_d        = sel_q;
      reset_conn_d = 1'b0;
      strobe_d     = 1'b0;
      fault_d      = fault_q & ~bus_if.clear_fault_i;
      timed_out    = (cnt_q == TIMEOUT_CYCLES - 1);

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus_if.enable_i || bus_if.trigger_i) state_d = S_START_T;
         end
         S_START_T: begin
            cnt_d   = '0;
            state_d = S_WAIT_T;
         end
         S_START_H: begin
            cnt_d   = '0;
            state_d = S_WAIT_H;
         end
         S_WAIT_T, S_WAIT_H: begin
            // an error pulse beats a coincident done: the data cannot be trusted
            if (bus_if.sens_error_i || (timed_out && !bus_if.sens_done_i)) begin
               cnt_d        = '0;
               retry_d      = retry_q + 32'd1;
               reset_conn_d = 1'b1;
               state_d      = S_RECOVER;
               if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            end else if (bus_if.sens_done_i) begin
               cnt_d   = '0;
               retry_d = '0;
               if (state_q == S_WAIT_T) begin
                  temp_raw_d   = bus_if.sens_data_i[13:0];
                  temp_valid_d = 1'b1;
                  state_d      = S_START_H;
               end else begin
                  rh_raw_d   = bus_if.sens_data_i[11:0];
                  rh_valid_d = 1'b1;
                  strobe_d   = 1'b1;
                  state_d    = S_GAP;
               end
            end
         end
         S_RECOVER: begin
            if (cnt_q == RECOVER_CYCLES - 1) begin
               cnt_d = '0;
               if (retry_q < MAX_RETRY) begin
                  state_d = sel_q ? S_START_H : S_START_T;
               end else begin
                  fault_d = 1'b1;
                  retry_d = '0;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == PERIOD_CYCLES - 1) begin
               cnt_d   = '0;
               state_d = bus_if.enable_i ? S_START_T : S_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      start_d = (state_d == S_START_T) || (state_d == S_START_H);
      if (state_d == S_START_T) begin
         sel_d = 1'b0;
      end else if (state_d == S_START_H) begin
         sel_d = 1'b1;
      end
      busy_d = (state_d != S_IDLE) && (state_d != S_GAP);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         retry_q      <= '0;
         err_count_q  <= '0;
         temp_raw_q   <= '0;
         rh_raw_q     <= '0;
         temp_valid_q <= 1'b0;
         rh_valid_q   <= 1'b0;
         start_q      <= 1'b0;
         sel_q        <= 1'b0;
         reset_conn_q <= 1'b0;
         strobe_q     <= 1'b0;
         fault_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         err_count_q  <= err_count_d;
         temp_raw_q   <= temp_raw_d;
         rh_raw_q     <= rh_raw_d;
         temp_valid_q <= temp_valid_d;
         rh_valid_q   <= rh_valid_d;
         start_q      <= start_d;
         sel_q        <= sel_d;
         reset_conn_q <= reset_conn_d;
         strobe_q     <= strobe_d;
         fault_q      <= fault_d;
         busy_q       <= busy_d;
      end
   end

   assign bus_if.sens_start_o      = start_q;
   assign bus_if.sens_sel_o        = sel_q;
   assign bus_if.sens_reset_conn_o = reset_conn_q;
   assign bus_if.temp_raw_o        = temp_raw_q;
   assign bus_if.rh_raw_o          = rh_raw_q;
   assign bus_if.temp_valid_o      = temp_valid_q;
   assign bus_if.rh_valid_o        = rh_valid_q;
   assign bus_if.sample_strobe_o   = strobe_q;
   assign bus_if.fault_o           = fault_q;
   assign bus_if.err_count_o       = err_count_q;
   assign bus_if.busy_o            = busy_q;
endmodule

// File: tb/tb_sht10_meas_scheduler.sv
// tb/tb_sht10_meas_scheduler.sv - Scoreboard bench for the SHT10 measurement scheduler
// Directed stimulus pushes expected pulse events; a negedge monitor pops and compares them.
module tb_sht10_meas_scheduler;
   localparam int EV_START  = 0;
   localparam int EV_RST    = 1;
   localparam int EV_STROBE = 2;

   typedef struct {
      int          kind;
      int          cyc;
      bit          sel;
      logic [13:0] temp;
      logic [11:0] rh;
      bit          tv;
      bit          rv;
      logic [7:0]  err;
      bit          fault;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   ev_t  mon_e;
   int   mon_k;
   bit   mon_bad;

   logic [13:0] m_temp;
   logic [11:0] m_rh;
   bit          m_tv, m_rv, m_fault;
   logic [7:0]  m_err;

   int T1, H1, T2, T2r, H2, T3, T3r, H3, T4, H4, T5, H5, T6, H6, T7, b;

   sht10_meas_scheduler_if sif();

   sht10_meas_scheduler #(
      .PERIOD_CYCLES (1000),
      .TIMEOUT_CYCLES(200),
      .RECOVER_CYCLES(50),
      .MAX_RETRY     (2)
   ) dut (
      .clock_i(clk),
      .reset_i(rst),
      .bus_if (sif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp_v);
      end
   endtask

   task automatic expect_ev(input int kind, input int at, input bit sel);
      ev_t e;
      e.kind = kind; e.cyc = at; e.sel = sel;
      e.temp = m_temp; e.rh = m_rh; e.tv = m_tv; e.rv = m_rv;
      e.err = m_err; e.fault = m_fault;
      exp_q.push_back(e);
   endtask

   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic respond(input int t, input bit done, input bit err, input logic [15:0] d);
      goto(t);
      sif.sens_done_i  = done;
      sif.sens_error_i = err;
      sif.sens_data_i  = d;
      goto(t + 1);
      sif.sens_done_i  = 1'b0;
      sif.sens_error_i = 1'b0;
   endtask

   function automatic logic [63:0] all_outputs();
      return 64'({sif.sens_start_o, sif.sens_sel_o, sif.sens_reset_conn_o, sif.temp_raw_o,
                  sif.rh_raw_o, sif.temp_valid_o, sif.rh_valid_o, sif.sample_strobe_o,
                  sif.fault_o, sif.err_count_o, sif.busy_o});
   endfunction

   always @(negedge clk) begin
      if (!rst && (sif.sens_start_o || sif.sens_reset_conn_o || sif.sample_strobe_o)) begin
         mon_k = sif.sens_start_o ? EV_START : (sif.sens_reset_conn_o ? EV_RST : EV_STROBE);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d", mon_k, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_bad = (mon_k != mon_e.kind) || (cyc != mon_e.cyc) ||
                      (mon_k != EV_STROBE && sif.sens_sel_o != mon_e.sel) ||
                      (sif.temp_raw_o != mon_e.temp) || (sif.rh_raw_o != mon_e.rh) ||
                      (sif.temp_valid_o != mon_e.tv) || (sif.rh_valid_o != mon_e.rv) ||
                      (sif.err_count_o != mon_e.err) || (sif.fault_o != mon_e.fault);
            if (mon_bad) begin
               errors++;
               $display("FAIL event got kind=%0d cyc=%0d sel=%0d temp=%h rh=%h tv=%0d rv=%0d err=%0d fault=%0d expected kind=%0d cyc=%0d sel=%0d temp=%h rh=%h tv=%0d rv=%0d err=%0d fault=%0d",
                        mon_k, cyc, sif.sens_sel_o, sif.temp_raw_o, sif.rh_raw_o, sif.temp_valid_o,
                        sif.rh_valid_o, sif.err_count_o, sif.fault_o, mon_e.kind, mon_e.cyc, mon_e.sel,
                        mon_e.temp, mon_e.rh, mon_e.tv, mon_e.rv, mon_e.err, mon_e.fault);
            end
         end
      end
   end

   initial begin
      sif.enable_i = 1'b0; sif.trigger_i = 1'b0; sif.clear_fault_i = 1'b0;
      sif.sens_done_i = 1'b0; sif.sens_error_i = 1'b0; sif.sens_data_i = '0;
      m_temp = '0; m_rh = '0; m_tv = 1'b0; m_rv = 1'b0; m_err = '0; m_fault = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", all_outputs(), 64'd0);
      rst = 1'b0;
      goto(cyc + 2);
      chk("idle_not_busy", 64'(sif.busy_o), 64'd0);

      // normal pair under enable
      b = cyc; sif.enable_i = 1'b1; T1 = b + 1;
      expect_ev(EV_START, T1, 1'b0);
      m_temp = 14'h1A2B; m_tv = 1'b1;
      expect_ev(EV_START, T1 + 101, 1'b1);
      respond(T1 + 100, 1'b1, 1'b0, 16'h1A2B);
      H1 = T1 + 101;
      m_rh = 12'h567; m_rv = 1'b1;
      expect_ev(EV_STROBE, H1 + 101, 1'b0);
      expect_ev(EV_START, H1 + 1101, 1'b0);
      respond(H1 + 100, 1'b1, 1'b0, 16'h0567);
      goto(H1 + 102);
      chk("gap_not_busy", 64'(sif.busy_o), 64'd0);

      // error then recover
      T2 = H1 + 1101;
      m_err = 8'd1;
      expect_ev(EV_RST, T2 + 11, 1'b0);
      expect_ev(EV_START, T2 + 61, 1'b0);
      respond(T2 + 10, 1'b0, 1'b1, 16'hFFFF);
      goto(T2 + 12);
      chk("recover_busy", 64'(sif.busy_o), 64'd1);
      chk("err_keeps_temp", 64'(sif.temp_raw_o), 64'h1A2B);
      T2r = T2 + 61;
      m_temp = 14'h1111;
      expect_ev(EV_START, T2r + 101, 1'b1);
      respond(T2r + 100, 1'b1, 1'b0, 16'hD111);
      H2 = T2r + 101;
      m_rh = 12'h222;
      expect_ev(EV_STROBE, H2 + 101, 1'b0);
      expect_ev(EV_START, H2 + 1101, 1'b0);
      respond(H2 + 100, 1'b1, 1'b0, 16'hF222);

      // done and error together in WAIT_T
      T3 = H2 + 1101;
      m_err = 8'd2;
      expect_ev(EV_RST, T3 + 21, 1'b0);
      expect_ev(EV_START, T3 + 71, 1'b0);
      respond(T3 + 20, 1'b1, 1'b1, 16'h3FFF);
      goto(T3 + 22);
      chk("dual_no_latch", 64'(sif.temp_raw_o), 64'h1111);
      T3r = T3 + 71;
      m_temp = 14'h0ABC;
      expect_ev(EV_START, T3r + 101, 1'b1);
      respond(T3r + 100, 1'b1, 1'b0, 16'h0ABC);
      H3 = T3r + 101;
      m_rh = 12'h333;
      expect_ev(EV_STROBE, H3 + 101, 1'b0);
      expect_ev(EV_START, H3 + 1101, 1'b0);
      respond(H3 + 100, 1'b1, 1'b0, 16'h0333);

      // humidity timeouts exhaust retries
      T4 = H3 + 1101;
      m_temp = 14'h0DEF;
      expect_ev(EV_START, T4 + 101, 1'b1);
      respond(T4 + 100, 1'b1, 1'b0, 16'h0DEF);
      H4 = T4 + 101;
      m_err = 8'd3;
      expect_ev(EV_RST, H4 + 201, 1'b1);
      expect_ev(EV_START, H4 + 251, 1'b1);
      m_err = 8'd4;
      expect_ev(EV_RST, H4 + 452, 1'b1);
      goto(H4 + 501);
      sif.clear_fault_i = 1'b1;
      goto(H4 + 502);
      chk("fault_beats_clear", 64'(sif.fault_o), 64'd1);
      chk("fault_rh_held", 64'(sif.rh_raw_o), 64'h333);
      chk("fault_err_count", 64'(sif.err_count_o), 64'd4);
      chk("fault_gap_not_busy", 64'(sif.busy_o), 64'd0);
      sif.enable_i = 1'b0;
      goto(H4 + 503);
      sif.clear_fault_i = 1'b0;
      chk("fault_cleared", 64'(sif.fault_o), 64'd0);
      goto(H4 + 700);
      sif.trigger_i = 1'b1;
      goto(H4 + 701);
      sif.trigger_i = 1'b0;
      goto(H4 + 1510);
      chk("gap_trigger_ignored_idle", 64'(sif.busy_o), 64'd0);

      // one-shot trigger
      b = cyc; sif.trigger_i = 1'b1; T5 = b + 1;
      expect_ev(EV_START, T5, 1'b0);
      goto(b + 1);
      sif.trigger_i = 1'b0;
      m_temp = 14'h0123;
      expect_ev(EV_START, T5 + 101, 1'b1);
      respond(T5 + 100, 1'b1, 1'b0, 16'h0123);
      H5 = T5 + 101;
      m_rh = 12'h045;
      expect_ev(EV_STROBE, H5 + 101, 1'b0);
      respond(H5 + 100, 1'b1, 1'b0, 16'h0045);
      goto(H5 + 1105);
      chk("oneshot_idle", 64'(sif.busy_o), 64'd0);

      // enable dropped mid-WAIT_H
      b = cyc; sif.enable_i = 1'b1; T6 = b + 1;
      expect_ev(EV_START, T6, 1'b0);
      m_temp = 14'h0456;
      expect_ev(EV_START, T6 + 101, 1'b1);
      respond(T6 + 100, 1'b1, 1'b0, 16'h0456);
      H6 = T6 + 101;
      goto(H6 + 50);
      sif.enable_i = 1'b0;
      m_rh = 12'h078;
      expect_ev(EV_STROBE, H6 + 101, 1'b0);
      respond(H6 + 100, 1'b1, 1'b0, 16'h0078);
      goto(H6 + 1110);
      chk("enable_drop_idle", 64'(sif.busy_o), 64'd0);

      // asynchronous reset during WAIT_H
      b = cyc; sif.trigger_i = 1'b1; T7 = b + 1;
      expect_ev(EV_START, T7, 1'b0);
      goto(b + 1);
      sif.trigger_i = 1'b0;
      m_temp = 14'h0999;
      expect_ev(EV_START, T7 + 101, 1'b1);
      respond(T7 + 100, 1'b1, 1'b0, 16'h0999);
      goto(T7 + 131);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", all_outputs(), 64'd0);
      goto(cyc + 3);
      rst = 1'b0;
      goto(cyc + 300);
      chk("post_reset_idle", 64'(sif.busy_o), 64'd0);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events got=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
